// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard
//   Sits between the FPU controller and the float register file. It registers
//   the controller writeback onto the register file write port and keeps a
//   per-register count of FPU results still in flight. Decode is stalled when
//   an issuing instruction reads a register with a pending result, or when an
//   FPU op would push its destination counter past its limit.
//
// Ports
//   clk, xrst            clock, asynchronous active-low reset
//   issue_valid          decode presents an instruction this cycle
//   issue_fpu            instruction is an FPU op writing float rd
//   issue_use_rs/_rt     instruction reads float issue_rs / issue_rt
//   issue_rs/_rt/_rd     float source and destination indices
//   wb_enable/addr/data  FPU controller result
//   wb_float             result targets the float register file
//   stall                combinational hold to decode
//   fr_we/addr/data      registered float register file write port
//   pending              bit i set while register i has results in flight
//   err                  sticky: a result retired to a register with zero count
module fpu_scoreboard #(
    parameter int CNT_W = 3
) (
    input  logic        clk,
    input  logic        xrst,
    input  logic        issue_valid,
    input  logic        issue_fpu,
    input  logic        issue_use_rs,
    input  logic        issue_use_rt,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic [4:0]  issue_rd,
    input  logic        wb_enable,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        wb_float,
    output logic        stall,
    output logic        fr_we,
    output logic [4:0]  fr_addr,
    output logic [31:0] fr_data,
    output logic [31:0] pending,
    output logic        err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt [32];
    logic             accept;
    logic [31:0]      inc_vec;
    logic [31:0]      ret_vec;

    // Hazard check against the current counters. A result is only released
    // once its counter has dropped, i.e. the cycle after fr_we, so readers see
    // the written value without any bypass path.
    always_comb begin
        stall = 1'b0;
        if (issue_valid) begin
            stall = (issue_use_rs && (cnt[issue_rs] != '0)) ||
                    (issue_use_rt && (cnt[issue_rt] != '0)) ||
                    (issue_fpu    && (cnt[issue_rd] == CNT_MAX));
        end
    end

    assign accept = issue_valid & issue_fpu & ~stall;

    // One-hot increment / retire selects; at most one of each per cycle.
    always_comb begin
        inc_vec = '0;
        ret_vec = '0;
        if (accept) begin
            inc_vec[issue_rd] = 1'b1;
        end
        if (fr_we) begin
            ret_vec[fr_addr] = 1'b1;
        end
    end

    // Write stage: one cycle from controller writeback to register file port.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            fr_we   <= 1'b0;
            fr_addr <= '0;
            fr_data <= '0;
        end else begin
            fr_we   <= wb_enable & wb_float;
            fr_addr <= wb_addr;
            fr_data <= wb_data;
        end
    end

    // Counter update. The decrement lands on the same edge the register file
    // captures fr_data. A retire against an empty counter is flagged but the
    // counter stays at zero rather than wrapping.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < 32; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (inc_vec[i] && !ret_vec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (ret_vec[i] && !inc_vec[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            err <= 1'b0;
        end else if (fr_we && (cnt[fr_addr] == '0)) begin
            err <= 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < 32; i++) begin
            pending[i] = (cnt[i] != '0);
        end
    end

endmodule

// File: tb/tb_fpu_scoreboard.sv
// Bench for fpu_scoreboard. Register file writes are checked against a queue
// of expected {addr,data} entries pushed whenever a float writeback is driven.
module tb_fpu_scoreboard;

    logic        clk;
    logic        xrst;
    logic        issue_valid;
    logic        issue_fpu;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic [4:0]  issue_rd;
    logic        wb_enable;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_float;
    logic        stall;
    logic        fr_we;
    logic [4:0]  fr_addr;
    logic [31:0] fr_data;
    logic [31:0] pending;
    logic        err;

    int n_chk  = 0;
    int n_pass = 0;
    logic [36:0] exp_q [$];
    logic [36:0] mon_e;

    fpu_scoreboard #(.CNT_W(3)) dut (
        .clk          (clk),
        .xrst         (xrst),
        .issue_valid  (issue_valid),
        .issue_fpu    (issue_fpu),
        .issue_use_rs (issue_use_rs),
        .issue_use_rt (issue_use_rt),
        .issue_rs     (issue_rs),
        .issue_rt     (issue_rt),
        .issue_rd     (issue_rd),
        .wb_enable    (wb_enable),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .wb_float     (wb_float),
        .stall        (stall),
        .fr_we        (fr_we),
        .fr_addr      (fr_addr),
        .fr_data      (fr_data),
        .pending      (pending),
        .err          (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid  = 1'b0;
        issue_fpu    = 1'b0;
        issue_use_rs = 1'b0;
        issue_use_rt = 1'b0;
        issue_rs     = '0;
        issue_rt     = '0;
        issue_rd     = '0;
        wb_enable    = 1'b0;
        wb_float     = 1'b0;
        wb_addr      = '0;
        wb_data      = '0;
    endtask

    task automatic issue_op(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_fpu   = 1'b1;
        issue_rd    = rd;
    endtask

    task automatic drive_wb(input logic [4:0] a, input logic [31:0] d);
        wb_enable = 1'b1;
        wb_float  = 1'b1;
        wb_addr   = a;
        wb_data   = d;
        exp_q.push_back({a, d});
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
        idle();
    endtask

    // Register file write monitor.
    always @(negedge clk) begin
        if (xrst && fr_we) begin
            if (exp_q.size() == 0) begin
                chk("wb_extra", fr_we, 1'b0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("fr_addr", fr_addr, mon_e[36:32]);
                chk("fr_data", fr_data, mon_e[31:0]);
            end
        end
    end

    initial begin
        idle();
        xrst = 1'b0;
        repeat (2) @(posedge clk);
        #1 xrst = 1'b1;

        // Reset state
        issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = 5'd5;
        settle();
        chk("rst_pending", pending, 32'h0);
        chk("rst_fr_we", fr_we, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_stall", stall, 1'b0);
        next_cyc();

        // Asynchronous reset mid-operation with cnt[5]=2, fr_we=1, err=1
        issue_op(5'd5);
        settle();
        chk("ar_acc_stall", stall, 1'b0);
        next_cyc();
        issue_op(5'd5);
        drive_wb(5'd20, 32'hA5A5_0014);
        settle();
        next_cyc();
        drive_wb(5'd21, 32'h5A5A_0015);
        settle();
        chk("ar_pending", pending, 32'h0000_0020);
        next_cyc();
        chk("ar_err_pre", err, 1'b1);
        chk("ar_we_pre", fr_we, 1'b1);
        #2 xrst = 1'b0;
        #1;
        chk("ar_pending0", pending, 32'h0);
        chk("ar_we0", fr_we, 1'b0);
        chk("ar_err0", err, 1'b0);
        exp_q.delete();
        @(posedge clk);
        #3 xrst = 1'b1;
        next_cyc();
        chk("ar_pending_after", pending, 32'h0);

        // RAW stall on rd=3
        issue_op(5'd3);
        settle();
        chk("raw_acc_stall", stall, 1'b0);
        next_cyc();
        for (int k = 1; k <= 5; k++) begin
            issue_valid = 1'b1; issue_use_rs = 1'b1; issue_rs = 5'd3;
            if (k == 3) drive_wb(5'd3, 32'h3F80_0000);
            settle();
            chk("raw_stall", stall, (k <= 4));
            if (k == 4) begin
                chk("raw_fr_we", fr_we, 1'b1);
                chk("raw_fr_addr", fr_addr, 5'd3);
            end
            next_cyc();
        end

        // Back-to-back accepts to rd=7
        for (int k = 0; k <= 7; k++) begin
            if (k < 3) issue_op(5'd7);
            if (k >= 3 && k <= 5) drive_wb(5'd7, 32'h4000_0000 + k);
            settle();
            if (k < 3) chk("b2b_stall", stall, 1'b0);
            chk("b2b_pend7", pending[7], (k >= 1 && k <= 6));
            next_cyc();
        end

        // Simultaneous increment and retire on rd=4
        for (int k = 0; k <= 9; k++) begin
            if (k == 0 || k == 4) issue_op(5'd4);
            if (k == 3 || k == 7) drive_wb(5'd4, 32'h4040_0000 + k);
            settle();
            if (k == 4) chk("ir_stall", stall, 1'b0);
            chk("ir_pend4", pending[4], (k >= 1 && k <= 8));
            next_cyc();
        end

        // Unused second operand
        issue_op(5'd9);
        settle();
        next_cyc();
        issue_op(5'd10); issue_use_rs = 1'b1; issue_rs = 5'd1;
        issue_use_rt = 1'b0; issue_rt = 5'd9;
        settle();
        chk("rt_unused_stall", stall, 1'b0);
        next_cyc();
        issue_op(5'd11); issue_use_rs = 1'b1; issue_rs = 5'd1;
        issue_use_rt = 1'b1; issue_rt = 5'd9;
        settle();
        chk("rt_used_stall", stall, 1'b1);
        next_cyc();
        drive_wb(5'd9, 32'h4110_0000);
        settle();
        next_cyc();
        drive_wb(5'd10, 32'h4120_0000);
        settle();
        next_cyc();
        settle();
        chk("rt_pending_mid", pending, 32'h0000_0400);
        next_cyc();
        settle();
        chk("rt_pending_end", pending, 32'h0);
        next_cyc();

        // Saturation at 7 on rd=2, plus a non-float writeback
        for (int k = 0; k < 7; k++) begin
            issue_op(5'd2);
            settle();
            chk("sat_acc_stall", stall, 1'b0);
            next_cyc();
        end
        issue_op(5'd2);
        wb_enable = 1'b1; wb_float = 1'b0; wb_addr = 5'd2; wb_data = 32'h1234_5678;
        settle();
        chk("sat_stall", stall, 1'b1);
        next_cyc();
        chk("nofloat_fr_we", fr_we, 1'b0);
        chk("sat_pend2", pending[2], 1'b1);
        for (int k = 0; k <= 8; k++) begin
            if (k < 7) drive_wb(5'd2, 32'hC000_0000 + k);
            settle();
            chk("sat_drain_pend2", pending[2], (k <= 7));
            next_cyc();
        end
        chk("sat_err", err, 1'b0);

        // Retire with zero count
        chk("err_pre", err, 1'b0);
        drive_wb(5'd12, 32'hDEAD_BEEF);
        settle();
        next_cyc();
        chk("err_fr_we", fr_we, 1'b1);
        chk("err_fr_addr", fr_addr, 5'd12);
        next_cyc();
        chk("err_set", err, 1'b1);
        chk("err_pending", pending, 32'h0);
        repeat (3) next_cyc();
        chk("err_sticky", err, 1'b1);
        #2 xrst = 1'b0;
        #1;
        chk("err_cleared", err, 1'b0);
        @(posedge clk);
        #3 xrst = 1'b1;
        next_cyc();

        chk("wb_q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
